// File: rtl/dpll_trail_manager.sv
// Assignment trail for the DPLL SAT core: records decisions and implications and
// performs chronological backtracking by popping implications and flipping the last decision.
module dpll_trail_manager #(
    parameter int NUM_VARS  = 16,
    parameter int LIT_WIDTH = 6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            op_valid,
    input  logic [1:0]                      op_code,
    input  logic [LIT_WIDTH-1:0]            op_lit,
    output logic                            op_ready,
    output logic                            op_err,
    output logic [NUM_VARS:1]               assigned,
    output logic [NUM_VARS:1]               value,
    output logic [$clog2(NUM_VARS+1)-1:0]   level,
    output logic [$clog2(NUM_VARS+1)-1:0]   depth,
    output logic                            bt_done,
    output logic                            unsat
);
    localparam int VAR_W = LIT_WIDTH - 1;
    localparam int CNT_W = $clog2(NUM_VARS + 1);
    localparam int IDX_W = $clog2(NUM_VARS);

    localparam logic [1:0] OP_DECIDE = 2'd0;
    localparam logic [1:0] OP_IMPLY  = 2'd1;
    localparam logic [1:0] OP_BT     = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_BT, ST_UNSAT} state_t;
    typedef struct packed {
        logic [VAR_W-1:0] var_idx;
        logic             pol;
        logic             is_dec;
    } entry_t;

    state_t              state_q, state_d;
    logic [NUM_VARS:1]   assigned_q, assigned_d, value_q, value_d;
    logic [CNT_W-1:0]    level_q, level_d, depth_q, depth_d;
    logic                unsat_q, unsat_d, op_err_q, op_err_d, bt_done_q, bt_done_d;
    entry_t              trail_q [NUM_VARS];
    entry_t              trail_d [NUM_VARS];

    logic                accept;
    logic [VAR_W-1:0]    lit_var;
    logic                lit_pol;
    logic [NUM_VARS:1]   lit_mask, top_mask;
    logic                lit_ok;
    logic [IDX_W-1:0]    top_idx, push_idx;
    entry_t              top;

    // One-hot mask for a variable index; all-zero for 0 or out-of-range indices.
    function automatic logic [NUM_VARS:1] var_mask(input logic [VAR_W-1:0] v);
        logic [NUM_VARS:1] m;
        for (int i = 1; i <= NUM_VARS; i++) m[i] = (v == VAR_W'(i));
        return m;
    endfunction

    assign accept   = op_valid && (state_q != ST_BT);
    assign lit_var  = op_lit[VAR_W-1:0];
    assign lit_pol  = op_lit[LIT_WIDTH-1];
    assign lit_mask = var_mask(lit_var);
    assign lit_ok   = (|lit_mask) && !(|(lit_mask & assigned_q));
    assign top_idx  = IDX_W'(depth_q - CNT_W'(1));
    assign push_idx = IDX_W'(depth_q);
    assign top      = trail_q[top_idx];
    assign top_mask = var_mask(top.var_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept && op_code == OP_BT) state_d = ST_BT;
            ST_BT: begin
                if (depth_q == '0)    state_d = ST_UNSAT;
                else if (top.is_dec) state_d = ST_IDLE;
            end
            ST_UNSAT: if (accept && op_code == OP_CLEAR) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready = (state_q != ST_BT);
        op_err   = op_err_q;
        bt_done  = bt_done_q;
        assigned = assigned_q;
        value    = value_q;
        level    = level_q;
        depth    = depth_q;
        unsat    = unsat_q;
    end

    always_comb begin
        assigned_d = assigned_q;
        value_d    = value_q;
        level_d    = level_q;
        depth_d    = depth_q;
        unsat_d    = unsat_q;
        op_err_d   = 1'b0;
        bt_done_d  = 1'b0;
        trail_d    = trail_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_code == OP_DECIDE || op_code == OP_IMPLY) begin
                        if (lit_ok) begin
                            assigned_d        = assigned_q | lit_mask;
                            value_d           = lit_pol ? (value_q | lit_mask) : value_q;
                            depth_d           = depth_q + CNT_W'(1);
                            level_d           = (op_code == OP_DECIDE) ? level_q + CNT_W'(1) : level_q;
                            trail_d[push_idx] = {lit_var, lit_pol, op_code == OP_DECIDE};
                        end else begin
                            op_err_d = 1'b1;
                        end
                    end else if (op_code == OP_CLEAR) begin
                        assigned_d = '0;
                        value_d    = '0;
                        level_d    = '0;
                        depth_d    = '0;
                        unsat_d    = 1'b0;
                    end
                end
            end
            ST_BT: begin
                if (depth_q == '0) begin
                    unsat_d = 1'b1;
                end else if (!top.is_dec) begin
                    assigned_d = assigned_q & ~top_mask;
                    value_d    = value_q & ~top_mask;
                    depth_d    = depth_q - CNT_W'(1);
                end else begin
                    // The flipped decision becomes an implication one level down.
                    trail_d[top_idx] = {top.var_idx, ~top.pol, 1'b0};
                    value_d          = value_q ^ top_mask;
                    level_d          = level_q - CNT_W'(1);
                    bt_done_d        = 1'b1;
                end
            end
            ST_UNSAT: begin
                if (accept) begin
                    if (op_code == OP_CLEAR) begin
                        assigned_d = '0;
                        value_d    = '0;
                        level_d    = '0;
                        depth_d    = '0;
                        unsat_d    = 1'b0;
                    end else begin
                        op_err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            assigned_q <= '0;
            value_q    <= '0;
            level_q    <= '0;
            depth_q    <= '0;
            unsat_q    <= 1'b0;
            op_err_q   <= 1'b0;
            bt_done_q  <= 1'b0;
        end else begin
            assigned_q <= assigned_d;
            value_q    <= value_d;
            level_q    <= level_d;
            depth_q    <= depth_d;
            unsat_q    <= unsat_d;
            op_err_q   <= op_err_d;
            bt_done_q  <= bt_done_d;
        end
    end

    // Trail contents are don't-care after reset; depth alone defines what is valid.
    always_ff @(posedge clk) begin
        trail_q <= trail_d;
    end

endmodule

// File: tb/tb_dpll_trail_manager.sv
// Directed bench for dpll_trail_manager: trail build, backtrack, UNSAT, illegal ops,
// full trail, back-pressure and asynchronous reset.
module tb_dpll_trail_manager;
    localparam logic [1:0] DECIDE = 2'd0;
    localparam logic [1:0] IMPLY  = 2'd1;
    localparam logic [1:0] BTRK   = 2'd2;
    localparam logic [1:0] CLR    = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [5:0]  op_lit;
    logic        op_ready, op_err, bt_done, unsat;
    logic [16:1] assigned, value;
    logic [4:0]  level, depth;

    int n_tests = 0;
    int n_fail  = 0;

    dpll_trail_manager #(.NUM_VARS(16), .LIT_WIDTH(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_code  (op_code),
        .op_lit   (op_lit),
        .op_ready (op_ready),
        .op_err   (op_err),
        .assigned (assigned),
        .value    (value),
        .level    (level),
        .depth    (depth),
        .bt_done  (bt_done),
        .unsat    (unsat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one op at the falling edge; returns 1 time unit after the accepting edge.
    task automatic do_op(input logic [1:0] code, input logic [5:0] lit);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = code;
        op_lit   = lit;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bt_seen;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_code  = 2'd0;
        op_lit   = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",    op_ready, 1);
        chk("rst_assigned", assigned, 0);
        chk("rst_value",    value,    0);
        chk("rst_level",    level,    0);
        chk("rst_depth",    depth,    0);
        chk("rst_flags",    {op_err, bt_done, unsat}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Trail build and backtrack
        do_op(DECIDE, 6'h23);
        chk("t1_dec_assigned", assigned, 16'h0004);
        chk("t1_dec_level",    level,    1);
        do_op(IMPLY,  6'h05);
        do_op(DECIDE, 6'h07);
        do_op(IMPLY,  6'h21);
        chk("t1_level",    level,    2);
        chk("t1_depth",    depth,    4);
        chk("t1_assigned", assigned, 16'h0055);
        chk("t1_value",    value,    16'h0005);
        do_op(BTRK, 6'h00);
        chk("t1_bt_ready", op_ready, 0);
        step();
        chk("t1_pop_assigned", assigned, 16'h0054);
        chk("t1_pop_depth",    depth,    3);
        chk("t1_pop_bt_done",  bt_done,  0);
        step();
        chk("t1_flip_value", value,    16'h0044);
        chk("t1_flip_level", level,    1);
        chk("t1_flip_depth", depth,    3);
        chk("t1_bt_done",    bt_done,  1);
        chk("t1_ready",      op_ready, 1);
        chk("t1_no_err",     op_err,   0);
        step();
        chk("t1_bt_done_pulse", bt_done, 0);

        // UNSAT detection
        do_op(CLR, 6'h00);
        chk("t2_clr_assigned", assigned, 0);
        chk("t2_clr_depth",    depth,    0);
        do_op(IMPLY, 6'h22);
        chk("t2_imply_assigned", assigned, 16'h0002);
        do_op(BTRK, 6'h00);
        step();
        chk("t2_pop_depth",    depth,    0);
        chk("t2_pop_assigned", assigned, 0);
        step();
        chk("t2_unsat",    unsat,    1);
        chk("t2_no_done",  bt_done,  0);
        chk("t2_ready",    op_ready, 1);
        do_op(DECIDE, 6'h24);
        chk("t2_dec_err",      op_err,   1);
        chk("t2_dec_noeffect", assigned, 0);
        do_op(CLR, 6'h00);
        chk("t2_clr_err",      op_err,   0);
        chk("t2_clr_unsat",    unsat,    0);
        chk("t2_clr_assigned", assigned, 0);

        // Illegal literals
        do_op(DECIDE, 6'h23);
        chk("t3_ok_err", op_err, 0);
        do_op(DECIDE, 6'h03);
        chk("t3_dup_err",   op_err, 1);
        chk("t3_dup_level", level,  1);
        chk("t3_dup_depth", depth,  1);
        chk("t3_dup_value", value,  16'h0004);
        do_op(IMPLY, 6'h20);
        chk("t3_var0_err", op_err, 1);
        do_op(IMPLY, 6'h11);
        chk("t3_var17_err",   op_err,   1);
        chk("t3_var17_depth", depth,    1);
        step();
        chk("t3_err_pulse", op_err, 0);

        // Full trail: odd vars DECIDE with polarity 1, even vars IMPLY with polarity 0
        do_op(CLR, 6'h00);
        for (int i = 1; i <= 16; i++) begin
            logic [5:0] lit;
            lit = {i[0], i[4:0]};
            do_op(i[0] ? DECIDE : IMPLY, lit);
        end
        chk("t4_depth",    depth,    16);
        chk("t4_assigned", assigned, 16'hFFFF);
        chk("t4_level",    level,    8);
        chk("t4_value",    value,    16'h5555);
        do_op(BTRK, 6'h00);
        step();
        chk("t4_pop_assigned", assigned, 16'h7FFF);
        chk("t4_pop_depth",    depth,    15);
        step();
        chk("t4_flip_value", value,   16'h1555);
        chk("t4_flip_level", level,   7);
        chk("t4_flip_depth", depth,   15);
        chk("t4_bt_done",    bt_done, 1);

        // Back-pressure: IMPLY x9 held through BT
        do_op(CLR, 6'h00);
        do_op(DECIDE, 6'h21);
        do_op(IMPLY,  6'h02);
        do_op(BTRK,   6'h00);
        op_valid = 1'b1;
        op_code  = IMPLY;
        op_lit   = 6'h29;
        chk("t5_ready_bt0", op_ready, 0);
        step();
        chk("t5_ready_bt1",  op_ready, 0);
        chk("t5_held_pop",   assigned, 16'h0001);
        step();
        chk("t5_ready_idle", op_ready, 1);
        chk("t5_bt_done",    bt_done,  1);
        chk("t5_not_yet",    assigned, 16'h0001);
        chk("t5_flip_value", value,    16'h0000);
        step();
        op_valid = 1'b0;
        chk("t5_accept_assigned", assigned, 16'h0101);
        chk("t5_accept_value",    value,    16'h0100);
        chk("t5_accept_depth",    depth,    2);

        // Asynchronous reset during BT
        do_op(CLR, 6'h00);
        do_op(DECIDE, 6'h21);
        do_op(IMPLY,  6'h02);
        do_op(IMPLY,  6'h03);
        do_op(BTRK,   6'h00);
        step();
        chk("t6_in_bt", op_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready",    op_ready, 1);
        chk("t6_rst_assigned", assigned, 0);
        chk("t6_rst_value",    value,    0);
        chk("t6_rst_counts",   {level, depth}, 0);
        chk("t6_rst_flags",    {op_err, bt_done, unsat}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bt_seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bt_done) bt_seen++;
        end
        chk("t6_no_bt_done", bt_seen, 0);
        chk("t6_ready",      op_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
